// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the three requesters (uc, dc, ic)
// and the downstream memory bus of mem_arbiter.
// slave  : the arbiter's view
// master : the environment's view (requesters plus memory)
interface mem_arbiter_if;
  // uncached MMIO requester
  logic [63:0] uc_addr;
  logic [63:0] uc_data;
  logic [7:0]  uc_mask;
  logic        uc_we;
  logic        uc_re;
  logic [63:0] uc_rdata;
  logic        uc_finish;
  // dcache refill / writeback requester
  logic [63:0] dc_addr;
  logic [63:0] dc_data;
  logic [7:0]  dc_mask;
  logic        dc_we;
  logic        dc_re;
  logic [63:0] dc_rdata;
  logic        dc_finish;
  // icache refill requester (read-only)
  logic [63:0] ic_addr;
  logic        ic_re;
  logic [63:0] ic_rdata;
  logic        ic_finish;
  // shared downstream bus
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_we;
  logic        bus_re;
  logic [63:0] bus_rdata;
  logic        bus_finish;

  modport slave (
    input  uc_addr, uc_data, uc_mask, uc_we, uc_re,
    output uc_rdata, uc_finish,
    input  dc_addr, dc_data, dc_mask, dc_we, dc_re,
    output dc_rdata, dc_finish,
    input  ic_addr, ic_re,
    output ic_rdata, ic_finish,
    output bus_addr, bus_wdata, bus_wmask, bus_we, bus_re,
    input  bus_rdata, bus_finish
  );

  modport master (
    output uc_addr, uc_data, uc_mask, uc_we, uc_re,
    input  uc_rdata, uc_finish,
    output dc_addr, dc_data, dc_mask, dc_we, dc_re,
    input  dc_rdata, dc_finish,
    output ic_addr, ic_re,
    input  ic_rdata, ic_finish,
    input  bus_addr, bus_wdata, bus_wmask, bus_we, bus_re,
    output bus_rdata, bus_finish
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way memory arbiter: uc, dc and ic share one downstream bus.
// One transaction at a time: IDLE (arbitrate and latch) -> BUSY (drive bus
// until bus_finish) -> RESP (one-cycle finish pulse) -> IDLE.
// Build option: define ysyx22040228_ARB_RR_EN for round-robin arbitration
// (uc -> dc -> ic -> uc, last winner lowest); otherwise fixed uc > dc > ic.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  arb
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [1:0] ID_UC = 2'd0;
  localparam logic [1:0] ID_DC = 2'd1;
  localparam logic [1:0] ID_IC = 2'd2;

  state_t      r_state, w_next;
  logic [1:0]  r_gnt, w_win;
  logic [2:0]  w_pend;
  logic [63:0] r_addr, r_data;
  logic [7:0]  r_mask;
  logic        r_we, r_re;
  logic [63:0] r_uc_rdata, r_dc_rdata, r_ic_rdata;

  logic [63:0] w_sel_addr, w_sel_data;
  logic [7:0]  w_sel_mask;
  logic        w_sel_we, w_sel_re;

  logic [63:0] w_bus_addr, w_bus_wdata;
  logic [7:0]  w_bus_wmask;
  logic        w_bus_we, w_bus_re;
  logic        w_fin_uc, w_fin_dc, w_fin_ic;

  assign w_pend = {arb.ic_re, arb.dc_we | arb.dc_re, arb.uc_we | arb.uc_re};

`ifdef ysyx22040228_ARB_RR_EN
  // r_ptr names the requester with the highest priority for the next grant
  logic [1:0] r_ptr;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    logic [2:0] s;
    s = {1'b0, p} + 3'(k);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // search from r_ptr upward (mod 3); the first pending requester wins
  always_comb begin
    w_win = ID_UC;
    for (int k = 2; k >= 0; k--) begin
      if (w_pend[rr_idx(r_ptr, k)]) w_win = rr_idx(r_ptr, k);
    end
  end

  // after a grant, the winner's successor becomes highest priority
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_ptr <= ID_UC;
    else if (r_state == S_IDLE && |w_pend)     r_ptr <= (w_win == ID_IC) ? ID_UC : w_win + 2'd1;
  end
`else
  // fixed priority uc > dc > ic
  always_comb begin
    w_win = ID_UC;
    if      (w_pend[0]) w_win = ID_UC;
    else if (w_pend[1]) w_win = ID_DC;
    else                w_win = ID_IC;
  end
`endif

  // request fields of the arbitration winner
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_mask = '0;
    w_sel_we   = 1'b0;
    w_sel_re   = 1'b0;
    case (w_win)
      ID_UC: begin
        w_sel_addr = arb.uc_addr; w_sel_data = arb.uc_data; w_sel_mask = arb.uc_mask;
        w_sel_we   = arb.uc_we;   w_sel_re   = arb.uc_re;
      end
      ID_DC: begin
        w_sel_addr = arb.dc_addr; w_sel_data = arb.dc_data; w_sel_mask = arb.dc_mask;
        w_sel_we   = arb.dc_we;   w_sel_re   = arb.dc_re;
      end
      default: begin
        w_sel_addr = arb.ic_addr;
        w_sel_re   = arb.ic_re;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and bus / finish outputs
  always_comb begin
    w_next      = r_state;
    w_bus_addr  = '0;
    w_bus_wdata = '0;
    w_bus_wmask = '0;
    w_bus_we    = 1'b0;
    w_bus_re    = 1'b0;
    w_fin_uc    = 1'b0;
    w_fin_dc    = 1'b0;
    w_fin_ic    = 1'b0;
    case (r_state)
      S_IDLE: if (|w_pend) w_next = S_BUSY;
      S_BUSY: begin
        w_bus_addr  = r_addr;
        w_bus_wdata = r_data;
        w_bus_wmask = r_mask;
        w_bus_we    = r_we;
        w_bus_re    = r_re;
        if (arb.bus_finish) w_next = S_RESP;
      end
      S_RESP: begin
        w_fin_uc = (r_gnt == ID_UC);
        w_fin_dc = (r_gnt == ID_DC);
        w_fin_ic = (r_gnt == ID_IC);
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // latch the winner in IDLE; capture read data into the granted port on completion.
  // we+re together is a write, so re is masked off at latch time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt      <= ID_UC;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_uc_rdata <= '0;
      r_dc_rdata <= '0;
      r_ic_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && |w_pend) begin
        r_gnt  <= w_win;
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_mask <= w_sel_mask;
        r_we   <= w_sel_we;
        r_re   <= w_sel_re & ~w_sel_we;
      end
      if (r_state == S_BUSY && arb.bus_finish) begin
        case (r_gnt)
          ID_UC:   r_uc_rdata <= arb.bus_rdata;
          ID_DC:   r_dc_rdata <= arb.bus_rdata;
          default: r_ic_rdata <= arb.bus_rdata;
        endcase
      end
    end
  end

  // every output is forced low while reset is asserted
  assign arb.bus_addr  = rst_n ? w_bus_addr  : '0;
  assign arb.bus_wdata = rst_n ? w_bus_wdata : '0;
  assign arb.bus_wmask = rst_n ? w_bus_wmask : '0;
  assign arb.bus_we    = rst_n & w_bus_we;
  assign arb.bus_re    = rst_n & w_bus_re;
  assign arb.uc_finish = rst_n & w_fin_uc;
  assign arb.dc_finish = rst_n & w_fin_dc;
  assign arb.ic_finish = rst_n & w_fin_ic;
  assign arb.uc_rdata  = rst_n ? r_uc_rdata : '0;
  assign arb.dc_rdata  = rst_n ? r_dc_rdata : '0;
  assign arb.ic_rdata  = rst_n ? r_ic_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a random phase, all checked
// every cycle against a transaction-level model kept in this file.
// Honours ysyx22040228_ARB_RR_EN for the arbitration order it expects.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if arb();
  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .arb(arb));

  int n_chk = 0;
  int n_err = 0;

  // model: one transaction in flight, mode 0 idle / 1 on bus / 2 responding
  bit          m_valid;
  int          m_mode, m_g, m_ptr;
  logic [63:0] m_addr, m_data;
  logic [7:0]  m_mask;
  logic        m_wr, m_rd;
  logic [63:0] m_rdata [3];

  // observation
  int          stepno, first_busy, obs_fin_step;
  int          obs_cnt [3];
  int          obs_order [$];
  logic [63:0] obs_rd [3];
  logic [63:0] fb_addr, fb_wdata;
  logic [7:0]  fb_mask;
  logic        fb_we, fb_re;
  logic [2:0]  fin_seen;
  logic        busy_seen;

  // stimulus state
  bit          act [3];
  bit          hold [3];
  int          raised [3];
  int          bcnt, cur_lat, lat_fixed;
  bit          resp_fixed_en, rnd_en;
  logic [63:0] resp_fixed;

  task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin n_err++; $display("FAIL %s: got %h expected %h", n, a, e); end
  endtask
  task automatic chk1(input string n, input logic a, input logic e);
    n_chk++;
    if (a !== e) begin n_err++; $display("FAIL %s: got %b expected %b", n, a, e); end
  endtask
  task automatic chki(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin n_err++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
  endtask

  function automatic logic get_fin(input int i);
    case (i) 0: return arb.uc_finish; 1: return arb.dc_finish; default: return arb.ic_finish; endcase
  endfunction
  function automatic logic [63:0] get_rdata(input int i);
    case (i) 0: return arb.uc_rdata; 1: return arb.dc_rdata; default: return arb.ic_rdata; endcase
  endfunction

  // first pending requester counting up from ptr (mod 3)
  function automatic int pick(input logic [2:0] pend, input int ptr);
    for (int k = 0; k < 3; k++) if (pend[(ptr + k) % 3]) return (ptr + k) % 3;
    return 0;
  endfunction

  task automatic model_update();
    logic [2:0] pend;
    int g;
    if (!rst_n) begin
      m_valid = 1; m_mode = 0; m_g = 0; m_ptr = 0;
      m_addr = '0; m_data = '0; m_mask = '0; m_wr = 0; m_rd = 0;
      for (int i = 0; i < 3; i++) m_rdata[i] = '0;
    end else if (m_valid) begin
      case (m_mode)
        0: begin
          pend = {arb.ic_re, arb.dc_we | arb.dc_re, arb.uc_we | arb.uc_re};
          if (pend != 3'b000) begin
            g = pick(pend, m_ptr);
`ifdef ysyx22040228_ARB_RR_EN
            m_ptr = (g + 1) % 3;
`endif
            m_g = g;
            case (g)
              0: begin m_addr = arb.uc_addr; m_data = arb.uc_data; m_mask = arb.uc_mask;
                       m_wr = arb.uc_we; m_rd = arb.uc_re & ~arb.uc_we; end
              1: begin m_addr = arb.dc_addr; m_data = arb.dc_data; m_mask = arb.dc_mask;
                       m_wr = arb.dc_we; m_rd = arb.dc_re & ~arb.dc_we; end
              default: begin m_addr = arb.ic_addr; m_data = '0; m_mask = '0; m_wr = 0; m_rd = 1; end
            endcase
            m_mode = 1;
          end
        end
        1: if (arb.bus_finish) begin m_rdata[m_g] = arb.bus_rdata; m_mode = 2; end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic compare();
    logic on;
    on = rst_n && (m_mode == 1);
    chk64("bus_addr",  arb.bus_addr,  on ? m_addr : 64'h0);
    chk64("bus_wdata", arb.bus_wdata, on ? m_data : 64'h0);
    chk64("bus_wmask", {56'h0, arb.bus_wmask}, on ? {56'h0, m_mask} : 64'h0);
    chk1("bus_we", arb.bus_we, on & m_wr);
    chk1("bus_re", arb.bus_re, on & m_rd);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("finish[%0d]", i), get_fin(i), rst_n && (m_mode == 2) && (m_g == i));
      chk64($sformatf("rdata[%0d]", i), get_rdata(i), rst_n ? m_rdata[i] : 64'h0);
    end
  endtask

  task automatic raise(input int i, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] m, input logic we, input logic re);
    case (i)
      0: begin arb.uc_addr = a; arb.uc_data = d; arb.uc_mask = m; arb.uc_we = we; arb.uc_re = re; end
      1: begin arb.dc_addr = a; arb.dc_data = d; arb.dc_mask = m; arb.dc_we = we; arb.dc_re = re; end
      default: begin arb.ic_addr = a; arb.ic_re = 1'b1; end
    endcase
    act[i] = 1; raised[i]++;
  endtask

  task automatic drop(input int i);
    case (i)
      0: begin arb.uc_we = 1'b0; arb.uc_re = 1'b0; end
      1: begin arb.dc_we = 1'b0; arb.dc_re = 1'b0; end
      default: arb.ic_re = 1'b0;
    endcase
    act[i] = 0;
  endtask

  task automatic random_drive();
    int k;
    if (!busy_seen && !arb.bus_finish && $urandom_range(0, 15) == 0) begin
      arb.bus_finish = 1'b1; arb.bus_rdata = {$urandom, $urandom};
    end
    for (int i = 0; i < 3; i++) begin
      if (!act[i] && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        raise(i, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), k >= 1, k != 1);
      end else if (act[i] && $urandom_range(0, 7) == 0) begin
        // change a pending request's fields; must not disturb an already latched one
        case (i)
          0: begin arb.uc_addr = {$urandom, $urandom}; arb.uc_data = {$urandom, $urandom}; end
          1: begin arb.dc_addr = {$urandom, $urandom}; arb.dc_data = {$urandom, $urandom}; end
          default: arb.ic_addr = {$urandom, $urandom};
        endcase
      end
    end
  endtask

  // one clock: compare and observe at negedge, advance model at posedge, drive at posedge+1
  task automatic step();
    @(negedge clk);
    stepno++;
    if (m_valid) compare();
    fin_seen  = {arb.ic_finish, arb.dc_finish, arb.uc_finish};
    busy_seen = arb.bus_we | arb.bus_re;
    for (int i = 0; i < 3; i++) if (fin_seen[i]) begin
      obs_cnt[i]++; obs_order.push_back(i); obs_rd[i] = get_rdata(i); obs_fin_step = stepno;
    end
    if (busy_seen && first_busy < 0) begin
      first_busy = stepno; fb_addr = arb.bus_addr; fb_wdata = arb.bus_wdata;
      fb_mask = arb.bus_wmask; fb_we = arb.bus_we; fb_re = arb.bus_re;
    end
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 3; i++) if (fin_seen[i] && !hold[i] && act[i]) drop(i);
    // memory responder: bus_finish in the cur_lat-th bus cycle
    if (arb.bus_finish) begin
      arb.bus_finish = 1'b0; bcnt = 0;
    end else if (busy_seen) begin
      if (bcnt == 0) cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(2, 6));
      bcnt++;
      if (bcnt == cur_lat - 1) begin
        arb.bus_finish = 1'b1;
        arb.bus_rdata  = resp_fixed_en ? resp_fixed : {$urandom, $urandom};
      end
    end else bcnt = 0;
    if (rnd_en) random_drive();
  endtask

  task automatic reset_obs();
    stepno = 0; first_busy = -1; obs_fin_step = -1; obs_order.delete();
    for (int i = 0; i < 3; i++) begin obs_cnt[i] = 0; obs_rd[i] = '0; raised[i] = 0; end
  endtask

  task automatic wait_done(input int need, input int limit, input string n);
    while (obs_order.size() < need && stepno < limit) step();
    chki({n, "_done"}, obs_order.size(), need);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  task automatic single(input int id);
    reset_obs();
    raise(id, 64'h8000_0100, 64'h55, 8'hff, id == 0, id != 0);
    wait_done(1, 30, $sformatf("single%0d", id));
    repeat (2) step();
  endtask

  task automatic triple(input int e0, input int e1, input int e2, input string n);
    logic [63:0] ex_addr [3];
    logic [63:0] ex_data [3];
    logic [7:0]  ex_mask [3];
    logic        ex_we   [3];
    int          eo      [3];
    ex_addr = '{64'ha000_03f8, 64'h8000_2000, 64'h8000_3000};
    ex_data = '{64'h41, 64'h0, 64'h0};
    ex_mask = '{8'h01, 8'h00, 8'h00};
    ex_we   = '{1'b1, 1'b0, 1'b0};
    eo      = '{e0, e1, e2};
    reset_obs();
    raise(0, ex_addr[0], ex_data[0], ex_mask[0], 1'b1, 1'b0);
    raise(1, ex_addr[1], ex_data[1], ex_mask[1], 1'b0, 1'b1);
    raise(2, ex_addr[2], ex_data[2], ex_mask[2], 1'b0, 1'b1);
    wait_done(3, 60, n);
    for (int k = 0; k < 3; k++) begin
      chki($sformatf("%s_order%0d", n, k), (k < obs_order.size()) ? obs_order[k] : -1, eo[k]);
      chki($sformatf("%s_cnt%0d", n, k), obs_cnt[k], 1);
    end
    chk64({n, "_bus_addr"}, fb_addr, ex_addr[e0]);
    chk64({n, "_bus_wdata"}, fb_wdata, ex_data[e0]);
    chk64({n, "_bus_wmask"}, {56'h0, fb_mask}, {56'h0, ex_mask[e0]});
    chk1({n, "_bus_we"}, fb_we, ex_we[e0]);
    chk1({n, "_bus_re"}, fb_re, ~ex_we[e0]);
    repeat (2) step();
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (busy_seen || m_mode != 0 || arb.bus_finish); k++) step();
    repeat (2) step();
  endtask

  initial begin
    arb.uc_addr = '0; arb.uc_data = '0; arb.uc_mask = '0; arb.uc_we = 0; arb.uc_re = 0;
    arb.dc_addr = '0; arb.dc_data = '0; arb.dc_mask = '0; arb.dc_we = 0; arb.dc_re = 0;
    arb.ic_addr = '0; arb.ic_re = 0; arb.bus_rdata = '0; arb.bus_finish = 0;
    m_valid = 0; m_mode = 0; m_g = 0; m_ptr = 0;
    bcnt = 0; cur_lat = 2; lat_fixed = 0; resp_fixed_en = 0; rnd_en = 0; resp_fixed = '0;
    busy_seen = 0; fin_seen = '0;
    for (int i = 0; i < 3; i++) begin act[i] = 0; hold[i] = 0; end
    reset_obs();

    // reset state
    apply_reset();
    chk64("rst_uc_rdata", arb.uc_rdata, 64'h0);
    chk1("rst_bus_re", arb.bus_re, 1'b0);
    chk1("rst_dc_finish", arb.dc_finish, 1'b0);
    step();

    // single dcache read, bus_finish in the 4th bus cycle
    lat_fixed = 4; resp_fixed_en = 1; resp_fixed = 64'h1122_3344_5566_7788;
    reset_obs();
    raise(1, 64'h8000_1000, 64'h0, 8'h0, 1'b0, 1'b1);
    wait_done(1, 30, "rd");
    chki("rd_first_busy", first_busy, 2);
    chk64("rd_bus_addr", fb_addr, 64'h8000_1000);
    chk1("rd_bus_re", fb_re, 1'b1);
    chk1("rd_bus_we", fb_we, 1'b0);
    chki("rd_fin_step", obs_fin_step, 6);
    chki("rd_dc_cnt", obs_cnt[1], 1);
    chki("rd_uc_cnt", obs_cnt[0], 0);
    chki("rd_ic_cnt", obs_cnt[2], 0);
    chk64("rd_dc_rdata", obs_rd[1], 64'h1122_3344_5566_7788);
    repeat (3) step();
    chki("rd_dc_cnt_after", obs_cnt[1], 1);

    // simultaneous requests after a prior ic grant, then after a prior uc grant
    lat_fixed = 0; resp_fixed_en = 0;
    single(2);
    triple(0, 1, 2, "sim_ic");
    single(0);
`ifdef ysyx22040228_ARB_RR_EN
    triple(1, 2, 0, "sim_uc");
`else
    triple(0, 1, 2, "sim_uc");
`endif

    // uc and dc held continuously
    apply_reset();
    reset_obs();
    hold[0] = 1; hold[1] = 1;
    raise(0, 64'h1000, 64'h0, 8'h0, 1'b0, 1'b1);
    raise(1, 64'h2000, 64'h0, 8'h0, 1'b0, 1'b1);
    wait_done(4, 80, "hold");
    begin
`ifdef ysyx22040228_ARB_RR_EN
      int eh [4] = '{0, 1, 0, 1};
`else
      int eh [4] = '{0, 0, 0, 0};
`endif
      for (int k = 0; k < 4; k++)
        chki($sformatf("hold_order%0d", k), (k < obs_order.size()) ? obs_order[k] : -1, eh[k]);
    end
    hold[0] = 0; hold[1] = 0; drop(0); drop(1);
    drain();

    // reset two cycles after grant abandons the transaction, held request is regranted
    apply_reset();
    lat_fixed = 6; resp_fixed_en = 1; resp_fixed = 64'hdead_beef_0bad_f00d;
    reset_obs();
    raise(1, 64'h8000_4000, 64'h0, 8'h0, 1'b0, 1'b1);
    while (first_busy < 0 && stepno < 10) step();
    chki("rb_first_busy", first_busy, 2);
    rst_n = 1'b0;
    step();
    chk1("rb_bus_re", arb.bus_re, 1'b0);
    chk1("rb_bus_we", arb.bus_we, 1'b0);
    chk64("rb_bus_addr", arb.bus_addr, 64'h0);
    chk1("rb_dc_finish", arb.dc_finish, 1'b0);
    step();
    rst_n = 1'b1;
    chki("rb_cnt_in_reset", obs_cnt[1], 0);
    lat_fixed = 3;
    while (obs_cnt[1] < 1 && stepno < 40) step();
    chki("rb_dc_cnt", obs_cnt[1], 1);
    chk64("rb_dc_rdata", obs_rd[1], 64'hdead_beef_0bad_f00d);
    chki("rb_other_cnt", obs_cnt[0] + obs_cnt[2], 0);
    repeat (3) step();

    // spurious bus_finish in IDLE
    reset_obs();
    arb.bus_finish = 1'b1; arb.bus_rdata = 64'hffff_ffff_ffff_ffff;
    repeat (3) step();
    chki("sp_fin_cnt", obs_order.size(), 0);
    chki("sp_no_busy", first_busy, -1);
    chk64("sp_dc_rdata", arb.dc_rdata, 64'hdead_beef_0bad_f00d);

    // minimum turnaround on an ic read
    lat_fixed = 2; resp_fixed = 64'h0123_4567_89ab_cdef;
    reset_obs();
    raise(2, 64'h8000_5000, 64'h0, 8'h0, 1'b0, 1'b1);
    wait_done(1, 20, "ic");
    chki("ic_first_busy", first_busy, 2);
    chki("ic_fin_step", obs_fin_step, 4);
    chk64("ic_rdata", obs_rd[2], 64'h0123_4567_89ab_cdef);
    repeat (2) step();

    // we and re together is a write
    reset_obs();
    raise(0, 64'h10, 64'haa, 8'hff, 1'b1, 1'b1);
    wait_done(1, 20, "wr_rd");
    chk1("wr_rd_we", fb_we, 1'b1);
    chk1("wr_rd_re", fb_re, 1'b0);
    chk64("wr_rd_wdata", fb_wdata, 64'haa);
    repeat (2) step();

    // random traffic
    lat_fixed = 0; resp_fixed_en = 0;
    reset_obs();
    rnd_en = 1;
    repeat (600) step();
    rnd_en = 0;
    for (int k = 0; k < 200 && (act[0] || act[1] || act[2] || m_mode != 0 || arb.bus_finish); k++) step();
    for (int i = 0; i < 3; i++) chki($sformatf("rnd_served%0d", i), obs_cnt[i], raised[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; three requesters, 64-bit address/data, 8-bit byte mask, all fixed.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 uc_addr/uc_data/uc_mask  in  64/64/8  uncached MMIO request: address, write data, byte mask.
REQ-006 uc_we, uc_re  in  1,1  uncached write and read request, held until uc_finish.
REQ-007 uc_rdata, uc_finish  out  64,1  uncached response data and one-cycle done pulse.
REQ-008 dc_addr/dc_data/dc_mask/dc_we/dc_re  in  64/64/8/1/1  dcache refill or writeback request, same rules as uc_*.
REQ-009 dc_rdata, dc_finish  out  64,1  dcache response.
REQ-010 ic_addr, ic_re  in  64,1  icache refill read request (read-only).
REQ-011 ic_rdata, ic_finish  out  64,1  icache response.
REQ-012 bus_addr/bus_wdata/bus_wmask/bus_we/bus_re  out  64/64/8/1/1  shared downstream memory request.
REQ-013 bus_rdata, bus_finish  in  64,1  downstream response; bus_finish is a one-cycle pulse.

Function
REQ-014 FSM states: IDLE, BUSY, RESP.
REQ-015 IDLE: a requester is pending when its we or re is high; if any is pending, the arbiter latches the winner's id, addr, data, mask, we and re, then moves to BUSY at the next edge.
REQ-016 Fixed priority without the configuration macro: uc > dc > ic.
REQ-017 BUSY: bus_* drive the latched request every cycle; the arbiter samples no new requests.
REQ-018 BUSY, bus_finish=1: latch bus_rdata, then move to RESP.
REQ-019 RESP (exactly one cycle): the granted <x>_finish=1 and <x>_rdata=latched data; then IDLE.
REQ-020 Outside RESP, every *_finish=0. Every *_rdata holds its last latched value.
REQ-021 Requesters drop we/re in the cycle after their finish pulse. The extra IDLE cycle after RESP prevents regranting a stale request.
REQ-022 Latency: request seen at edge N puts bus_* valid in cycle N+1. bus_finish in cycle M gives <x>_finish in cycle M+1. Minimum turnaround is 3 cycles per transaction.
REQ-023 we and re both high on one requester: treated as a write, with bus_we=1 and bus_re=0.
REQ-024 Write data passes through unmodified; byte masking is the requester's responsibility.
REQ-025 bus_finish in IDLE or RESP is ignored.
REQ-026 A request that changes while the arbiter is in BUSY has no effect on the latched transaction.

Reset
REQ-027 rst_n=0 at an edge: state=IDLE, grant cleared, round-robin pointer points to uc, and all latched registers are 0.
REQ-028 During reset and the following cycle, all outputs are 0.
REQ-029 Reset during BUSY abandons the transaction: no finish pulse is issued, and bus_we and bus_re go to 0 at the next edge.

Configuration
REQ-030 Macro ysyx22040228_ARB_RR_EN defined: round-robin arbitration. The requester granted last has lowest priority next. Order is uc -> dc -> ic -> uc.
REQ-031 Macro not defined: fixed priority per REQ-016, and no pointer register is synthesized.

Verification
REQ-032 Single read: dc_re=1, dc_addr=0x80001000, bus_rdata=0x1122334455667788 with bus_finish 4 cycles after grant -> bus_re=1 in grant+1; dc_finish pulses once with that data; the other finishes stay 0.
REQ-033 Simultaneous: uc_we (addr 0xa00003f8, data 0x41, mask 0x01), dc_re and ic_re all raised in the same cycle, fixed mode -> service order uc, dc, ic, each with exactly one finish pulse.
REQ-034 Same stimulus with ysyx22040228_ARB_RR_EN after a prior ic grant -> service order uc, dc, ic. After a prior uc grant -> order dc, ic, uc.
REQ-035 Starvation check in round-robin mode: uc and dc held continuously -> grants alternate uc, dc, uc, dc.
REQ-036 Reset mid-BUSY: rst_n=0 two cycles after grant -> no *_finish, all bus_* are 0. After rst_n=1 with dc_re still held -> dc regranted, and the completion is correct.
REQ-037 Spurious bus_finish in IDLE -> no finish output and no state change.
